pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter NUM_INSTR, default 14, meaning instruction-memory depth; fetch addresses >= NUM_INSTR are out of program.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the retired-instruction counter.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 instr  input  32  instruction word from the instruction memory, valid from ID onward.
REQ-006 branch_taken  input  1  ALU equality-compare result, sampled in EX only.
REQ-007 jr_target  input  8  low 8 bits of rs register value, sampled in EX only.
REQ-008 state  output  3  processor phase: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
REQ-009 pc  output  8  current fetch address to instruction memory.
REQ-010 link_addr  output  8  return address captured by jal.
REQ-011 halted  output  1  high while state==HALT.
REQ-012 retired  output  CNT_W  count of completed instructions.

Function
REQ-013 SHALL decode opcode=instr[31:26], funct=instr[5:0], imm=instr[15:0], target=instr[7:0].
REQ-014 Paths: R-type (op 000000, funct != 001000) IF>ID>EX>WB; jr (op 000000, funct 001000) IF>ID>EX; addiu (001001) IF>ID>EX>WB; lw (100011) IF>ID>EX>MEM>WB; sw (101011) IF>ID>EX>MEM; beq (000100)/bne (000101) IF>ID>EX; j (000010) IF>ID; jal (000011) IF>ID>WB.
REQ-015 Any other opcode in ID SHALL go to HALT, without altering pc or retired.
REQ-016 pc SHALL be held stable for the whole IF cycle; on IF>ID, pc <= pc+1 (mod 256).
REQ-017 beq/bne in EX: if branch_taken (beq) or !branch_taken (bne), pc <= pc + sign-extended imm[7:0] (mod 256); otherwise pc unchanged.
REQ-018 j/jal in ID: pc <= target; jal also sets link_addr <= pc (already-incremented value).
REQ-019 jr in EX: pc <= jr_target.
REQ-020 Each instruction's final state SHALL transition to IF and increment retired by 1, saturating at all-ones.
REQ-021 On any transition into IF, if the next pc >= NUM_INSTR, state SHALL go to HALT instead, and retired still counts the completing instruction.
REQ-022 HALT SHALL be absorbing; pc, link_addr, and retired hold until rst.
REQ-023 Cycles per instruction SHALL be exactly the path length of REQ-014; there are no stall states.
REQ-024 halted SHALL be combinationally equal to (state==HALT); all other outputs SHALL be registered.

Reset
REQ-025 When rst is high at posedge: state=IF, pc=0, link_addr=0, retired=0, halted=0.
REQ-026 rst SHALL take priority over every transition in any state, including HALT and mid-instruction, with no residual effect on the next instruction.
REQ-027 The first fetch after reset release SHALL be at pc=0 in the first cycle with rst low.

Verification
REQ-028 Reset then 0x24020000 (addiu) -> states IF,ID,EX,WB,IF; pc 0->1 after the first IF; retired=1 on return to IF.
REQ-029 At pc=3, beq offset 8 with branch_taken=1 -> pc=12 after EX; with branch_taken=0 -> pc=4.
REQ-030 At pc=10, bne imm=0xFFFB with branch_taken=0 -> pc=6; at pc=13, jal target 0 -> pc=0 and link_addr=14 after ID, WB follows.
REQ-031 lw -> 5-cycle IF..WB sequence; sw -> 4 cycles ending at MEM; jr with jr_target=14 and NUM_INSTR=14 -> HALT, halted=1, retired incremented.
REQ-032 Opcode 111111 in ID -> HALT next cycle with retired unchanged; rst asserted during EX of an lw -> state=IF, pc=0, retired=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle phase FSM and program counter
// for a small MIPS-like core with a retired-instruction counter.
module pc_sequencer #(
   parameter int NUM_INSTR = 14,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             branch_taken,
   input  logic [7:0]       jr_target,
   output logic [2:0]       state,
   output logic [7:0]       pc,
   output logic [7:0]       link_addr,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [31:0]      LIMIT = NUM_INSTR;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE =
      {{(CNT_W-1){1'b0}}, 1'b1};

   state_t st, st_nxt;
   logic [7:0] pc_nxt;
   logic [7:0] link_nxt;
   logic [CNT_W-1:0] ret_nxt;
   logic fin;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [15:0] imm;
   logic [7:0] target;
   logic unused_bits;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign target = instr[7:0];
   assign unused_bits = ^{instr[25:16], imm[15:8]};

   logic is_rtype, is_jr, is_addiu, is_lw, is_sw;
   logic is_beq, is_bne, is_j, is_jal, is_ex_class;

   // Opcode classification.
   always_comb begin
      is_jr    = (opcode == 6'b000000) && (funct == 6'b001000);
      is_rtype = (opcode == 6'b000000) && !is_jr;
      is_addiu = (opcode == 6'b001001);
      is_lw    = (opcode == 6'b100011);
      is_sw    = (opcode == 6'b101011);
      is_beq   = (opcode == 6'b000100);
      is_bne   = (opcode == 6'b000101);
      is_j     = (opcode == 6'b000010);
      is_jal   = (opcode == 6'b000011);
      is_ex_class = is_rtype | is_jr | is_addiu | is_lw |
                    is_sw | is_beq | is_bne;
   end

   // Next phase, pc and link; fin marks an instruction's last phase.
   always_comb begin
      st_nxt   = st;
      pc_nxt   = pc;
      link_nxt = link_addr;
      fin      = 1'b0;
      case (st)
         S_IF: begin
            st_nxt = S_ID;
            pc_nxt = pc + 8'd1;
         end
         S_ID: begin
            if (is_j) begin
               pc_nxt = target;
               fin    = 1'b1;
            end else if (is_jal) begin
               pc_nxt   = target;
               link_nxt = pc;
               st_nxt   = S_WB;
            end else if (is_ex_class) begin
               st_nxt = S_EX;
            end else begin
               st_nxt = S_HALT;
            end
         end
         S_EX: begin
            if (is_rtype || is_addiu) begin
               st_nxt = S_WB;
            end else if (is_lw || is_sw) begin
               st_nxt = S_MEM;
            end else if (is_jr) begin
               pc_nxt = jr_target;
               fin    = 1'b1;
            end else if (is_beq || is_bne) begin
               if (is_beq ? branch_taken : !branch_taken)
                  pc_nxt = pc + imm[7:0];
               fin = 1'b1;
            end else begin
               st_nxt = S_HALT;
            end
         end
         S_MEM: begin
            if (is_lw) st_nxt = S_WB;
            else       fin = 1'b1;
         end
         S_WB:    fin = 1'b1;
         S_HALT:  st_nxt = S_HALT;
         default: st_nxt = S_HALT;
      endcase
      if (fin)
         st_nxt = ({24'd0, pc_nxt} >= LIMIT) ? S_HALT : S_IF;
   end

   // Retire counter saturates instead of wrapping.
   always_comb begin
      ret_nxt = retired;
      if (fin && retired != CNT_MAX)
         ret_nxt = retired + CNT_ONE;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_IF;
         pc        <= 8'd0;
         link_addr <= 8'd0;
         retired   <= '0;
      end else begin
         st        <= st_nxt;
         pc        <= pc_nxt;
         link_addr <= link_nxt;
         retired   <= ret_nxt;
      end
   end

   assign state  = st;
   assign halted = (st == S_HALT);

endmodule
